// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - LCD panel timing generator with pixel prefetch and Avalon CSR
module lcd_timing_ctrl #(
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 45,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 22,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22
) (
    input  logic        csi_clk,
    input  logic        csi_reset_n,
    input  logic        avs_chipselect,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [31:0] coe_iPIXEL_DATA,
    output logic        coe_oREAD_EN,
    output logic        coe_oRST_n,
    output logic        coe_oLCD_DCLK,
    output logic        coe_oHSYNC_N,
    output logic        coe_oVSYNC_N,
    output logic        coe_oDE,
    output logic [7:0]  coe_oR,
    output logic [7:0]  coe_oG,
    output logic [7:0]  coe_oB
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    // Prefetch window: one pixel ahead of the active window
    localparam logic [HW-1:0] H_PRE_BEG  = HW'(H_SYNC + H_BP - 1);
    localparam logic [HW-1:0] H_PRE_END  = HW'(H_SYNC + H_BP + H_ACTIVE - 2);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic          en_q, en_d;
    logic          phase_q, phase_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          de_q, de_d;
    logic          read_en_q, read_en_d;
    logic          rst_n_q, rst_n_d;
    logic [23:0]   rgb_q, rgb_d;
    logic [31:0]   readdata_q, readdata_d;

    logic clr_frames, run, boundary, h_wrap, v_wrap;
    logic h_act, v_act, h_pre, vblank;

    // Bits of the bus that carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{coe_iPIXEL_DATA[7:0], avs_writedata[31:1]};

    // CSR writes, pixel-clock phase and raster counters
    always_comb begin
        en_d       = en_q;
        clr_frames = 1'b0;
        if (avs_chipselect && avs_write) begin
            case (avs_address)
                2'd0:    en_d = avs_writedata[0];
                2'd2:    clr_frames = 1'b1;
                default: ;
            endcase
        end
        // Counting only continues while enabled both before and after this edge,
        // so an enable edge starts a full two-cycle pixel period at h = v = 0.
        run      = en_q && en_d;
        boundary = run && phase_q;
        phase_d  = run ? ~phase_q : 1'b0;
        h_wrap   = boundary && (h_cnt_q == H_LAST);
        v_wrap   = h_wrap && (v_cnt_q == V_LAST);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en_d) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (boundary) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
            end
        end

        // A clear on the same edge as a frame wrap leaves the counter at zero
        if (clr_frames) begin
            frame_cnt_d = '0;
        end else if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Panel outputs decoded from the counter values that hold after this edge
    always_comb begin
        h_act = (h_cnt_d >= H_ACT_BEG) && (h_cnt_d <= H_ACT_END);
        v_act = (v_cnt_d >= V_ACT_BEG) && (v_cnt_d <= V_ACT_END);
        h_pre = (h_cnt_d >= H_PRE_BEG) && (h_cnt_d <= H_PRE_END);

        hsync_n_d = !(en_d && (h_cnt_d < H_SYNC_END));
        vsync_n_d = !(en_d && (v_cnt_d < V_SYNC_END));
        de_d      = en_d && h_act && v_act;
        read_en_d = en_d && h_pre && v_act;
        rst_n_d   = en_d && !((h_cnt_d == '0) && (v_cnt_d == '0));

        // Pixel fetched during a prefetch period is latched as that period ends
        if (!de_d) begin
            rgb_d = '0;
        end else if (boundary && read_en_q) begin
            rgb_d = coe_iPIXEL_DATA[31:8];
        end else begin
            rgb_d = rgb_q;
        end
    end

    // CSR read mux, registered for a fixed one-cycle read latency
    always_comb begin
        vblank     = !((v_cnt_q >= V_ACT_BEG) && (v_cnt_q <= V_ACT_END));
        readdata_d = readdata_q;
        if (avs_chipselect && avs_read) begin
            case (avs_address)
                2'd0:    readdata_d = {31'd0, en_q};
                2'd1:    readdata_d = {vblank, 15'd0, frame_cnt_q};
                default: readdata_d = '0;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            en_q        <= 1'b0;
            phase_q     <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
            de_q        <= 1'b0;
            read_en_q   <= 1'b0;
            rst_n_q     <= 1'b0;
            rgb_q       <= '0;
            readdata_q  <= '0;
        end else begin
            en_q        <= en_d;
            phase_q     <= phase_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            hsync_n_q   <= hsync_n_d;
            vsync_n_q   <= vsync_n_d;
            de_q        <= de_d;
            read_en_q   <= read_en_d;
            rst_n_q     <= rst_n_d;
            rgb_q       <= rgb_d;
            readdata_q  <= readdata_d;
        end
    end

    assign avs_readdata  = readdata_q;
    assign coe_oLCD_DCLK = phase_q;
    assign coe_oHSYNC_N  = hsync_n_q;
    assign coe_oVSYNC_N  = vsync_n_q;
    assign coe_oDE       = de_q;
    assign coe_oREAD_EN  = read_en_q;
    assign coe_oRST_n    = rst_n_q;
    assign coe_oR        = rgb_q[23:16];
    assign coe_oG        = rgb_q[15:8];
    assign coe_oB        = rgb_q[7:0];

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// tb/tb_lcd_timing_ctrl.sv - scoreboard bench for lcd_timing_ctrl against a raster model
module tb_lcd_timing_ctrl;

    localparam int HS = 2, HBP = 3, HA = 8, HFP = 3;
    localparam int VS = 1, VBP = 2, VA = 4, VFP = 2;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int FRAME_PIX = HT * VT;
    // dclk, hsync_n, vsync_n, de, read_en, rst_n, rgb
    localparam logic [29:0] IDLE = {6'b011000, 24'h0};

    logic        csi_clk = 1'b0;
    logic        csi_reset_n = 1'b0;
    logic        avs_chipselect = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] coe_iPIXEL_DATA = 32'd0;
    logic        coe_oREAD_EN, coe_oRST_n, coe_oLCD_DCLK;
    logic        coe_oHSYNC_N, coe_oVSYNC_N, coe_oDE;
    logic [7:0]  coe_oR, coe_oG, coe_oB;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    logic [31:0] din_hist [int];
    logic [29:0] panel_q [$];
    logic [31:0] csr_q [$];
    bit m_en = 1'b0;
    int m_t = 0;
    int m_en_edge = 0;
    int m_frames = 0;
    bit fixed_data = 1'b0;

    lcd_timing_ctrl #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut (
        .csi_clk(csi_clk), .csi_reset_n(csi_reset_n),
        .avs_chipselect(avs_chipselect), .avs_address(avs_address),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_write(avs_write), .avs_writedata(avs_writedata),
        .coe_iPIXEL_DATA(coe_iPIXEL_DATA), .coe_oREAD_EN(coe_oREAD_EN),
        .coe_oRST_n(coe_oRST_n), .coe_oLCD_DCLK(coe_oLCD_DCLK),
        .coe_oHSYNC_N(coe_oHSYNC_N), .coe_oVSYNC_N(coe_oVSYNC_N),
        .coe_oDE(coe_oDE), .coe_oR(coe_oR), .coe_oG(coe_oG), .coe_oB(coe_oB)
    );

    initial forever #5 csi_clk = ~csi_clk;

    function automatic bit pix_active(int h, int v);
        return (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    endfunction

    function automatic bit vblank_now();
        int v;
        v = m_en ? ((m_t / 2) / HT) % VT : 0;
        return !((v >= VS + VBP) && (v < VS + VBP + VA));
    endfunction

    // Expected panel state from elapsed time since enable
    function automatic logic [29:0] expect_panel();
        logic [29:0] e;
        logic [31:0] d;
        int p, h, v, q;
        bit de;
        if (!m_en) return IDLE;
        p  = m_t / 2;
        h  = p % HT;
        v  = (p / HT) % VT;
        q  = p + 1;
        de = pix_active(h, v);
        e[29] = (m_t % 2) == 1;
        e[28] = !(h < HS);
        e[27] = !(v < VS);
        e[26] = de;
        e[25] = pix_active(q % HT, (q / HT) % VT);
        e[24] = !(h == 0 && v == 0);
        if (de) begin
            d = din_hist[m_en_edge + 2 * p - 1];
            e[23:0] = d[31:8];
        end else begin
            e[23:0] = 24'h0;
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Reference model: advances on every clock edge and queues expectations
    initial forever begin
        bit wr, rd, new_en, clr;
        @(posedge csi_clk);
        edge_n++;
        if (!csi_reset_n) begin
            m_en = 1'b0;
            m_frames = 0;
        end else begin
            rd = avs_chipselect && avs_read;
            wr = avs_chipselect && avs_write;
            if (rd) begin
                case (avs_address)
                    2'd0:    csr_q.push_back({31'd0, m_en});
                    2'd1:    csr_q.push_back({vblank_now(), 15'd0, m_frames[15:0]});
                    default: csr_q.push_back(32'd0);
                endcase
            end
            new_en = m_en;
            clr = 1'b0;
            if (wr && avs_address == 2'd0) new_en = avs_writedata[0];
            if (wr && avs_address == 2'd2) clr = 1'b1;
            if (m_en && new_en) begin
                m_t++;
                if (m_t % 2 == 0 && (m_t / 2) % FRAME_PIX == 0) m_frames = (m_frames + 1) % 65536;
            end else if (!m_en && new_en) begin
                m_t = 0;
                m_en_edge = edge_n;
            end
            if (clr) m_frames = 0;
            m_en = new_en;
        end
        panel_q.push_back(expect_panel());
    end

    // Pixel source: fresh word every cycle, remembered by edge number
    initial forever begin
        @(posedge csi_clk);
        #1;
        coe_iPIXEL_DATA = fixed_data ? 32'hAABBCC00 : $urandom;
        din_hist[edge_n] = coe_iPIXEL_DATA;
    end

    // Monitor: compares DUT outputs on the falling edge
    initial forever begin
        logic [29:0] exp_p, got_p;
        logic [31:0] exp_r;
        @(negedge csi_clk);
        if (panel_q.size() > 0) begin
            exp_p = panel_q.pop_front();
            got_p = {coe_oLCD_DCLK, coe_oHSYNC_N, coe_oVSYNC_N, coe_oDE, coe_oREAD_EN,
                     coe_oRST_n, coe_oR, coe_oG, coe_oB};
            n_cmp++;
            if (got_p !== exp_p) begin
                n_bad++;
                $display("FAIL panel @%0t got=%h exp=%h", $time, got_p, exp_p);
            end
        end
        if (csr_q.size() > 0) begin
            exp_r = csr_q.pop_front();
            n_cmp++;
            if (avs_readdata !== exp_r) begin
                n_bad++;
                $display("FAIL readdata @%0t got=%h exp=%h", $time, avs_readdata, exp_r);
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge csi_clk);
            #1;
        end
    endtask

    task automatic csr_wr(logic [1:0] a, logic [31:0] d);
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(posedge csi_clk);
        #1;
        avs_chipselect = 1'b0; avs_write = 1'b0;
    endtask

    task automatic csr_rd(logic [1:0] a);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
        @(posedge csi_clk);
        #1;
        avs_chipselect = 1'b0; avs_read = 1'b0;
    endtask

    function automatic logic [29:0] panel_now();
        return {coe_oLCD_DCLK, coe_oHSYNC_N, coe_oVSYNC_N, coe_oDE, coe_oREAD_EN,
                coe_oRST_n, coe_oR, coe_oG, coe_oB};
    endfunction

    initial begin
        int k;
        idle(3);
        check("reset_panel", {2'b00, panel_now()}, {2'b00, IDLE});
        check("reset_readdata", avs_readdata, 32'd0);
        csi_reset_n = 1'b1;
        idle(2);
        csr_rd(2'd0);
        csr_rd(2'd1);

        // Three frames of random pixel data, then frame counter read and clear
        csr_wr(2'd0, 32'd1);
        idle(3 * 2 * FRAME_PIX);
        csr_rd(2'd1);
        csr_wr(2'd2, 32'h1234);
        csr_rd(2'd1);

        // Directed pixel word
        fixed_data = 1'b1;
        idle(2 * FRAME_PIX);
        fixed_data = 1'b0;

        // Disable during an active line, then restart
        k = 0;
        while (!coe_oDE && k < 4 * FRAME_PIX) begin
            idle(1);
            k++;
        end
        check("de_seen", {31'd0, coe_oDE}, 32'd1);
        idle($urandom_range(0, 3));
        csr_wr(2'd0, 32'd0);
        idle(5);
        csr_wr(2'd0, 32'd1);
        idle(40);

        // Clear landing on the same edge as a frame wrap
        csr_wr(2'd0, 32'd0);
        csr_wr(2'd0, 32'd1);
        idle(2 * FRAME_PIX - 1);
        csr_wr(2'd2, 32'd0);
        csr_rd(2'd1);

        // Random CSR traffic
        repeat (40) begin
            case ($urandom_range(0, 6))
                0:       csr_wr(2'd0, $urandom);
                1:       csr_wr(2'd2, $urandom);
                2, 3:    csr_rd(2'($urandom_range(0, 3)));
                4:       csr_wr({($urandom_range(0, 1) == 1), 1'b1}, $urandom);
                default: csr_wr(2'd0, 32'd1);
            endcase
            idle($urandom_range(0, 60));
        end

        // Asynchronous reset mid-frame
        csr_wr(2'd0, 32'd1);
        idle(100 + $urandom_range(0, 50));
        @(negedge csi_clk);
        #2;
        csi_reset_n = 1'b0;
        #1;
        check("async_reset_panel", {2'b00, panel_now()}, {2'b00, IDLE});
        check("async_reset_readdata", avs_readdata, 32'd0);
        idle(2);
        csi_reset_n = 1'b1;
        idle(1);
        csr_rd(2'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
